// File: rtl/multi_port_memctrl.sv
// multi_port_memctrl: arbitrates NUM_PORTS byte/half/word requests onto
// the single 8-bit RAM/IO bus, serialised little-endian byte by byte.
module multi_port_memctrl #(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic [NUM_PORTS-1:0]      req_i,
    input  logic [NUM_PORTS-1:0]      wr_i,
    input  logic [2*NUM_PORTS-1:0]    size_i,
    input  logic [32*NUM_PORTS-1:0]   addr_i,
    input  logic [32*NUM_PORTS-1:0]   wdata_i,
    input  logic [NUM_PORTS-1:0]      abort_i,
    output logic [NUM_PORTS-1:0]      done_o,
    output logic [31:0]               rdata_o,
    output logic [NUM_PORTS-1:0]      grant_o,
    output logic                      busy_o,
    input  logic                      io_buffer_full,
    input  logic [7:0]                ram_data_i,
    output logic [7:0]                ram_data_o,
    output logic [31:0]               ram_addr_o,
    output logic                      ram_wr_o
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic                 busy_q, busy_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          base_q, base_d;
    logic [31:0]          wdat_q, wdat_d;
    logic [7:0]           wbyte_q, wbyte_d;
    logic                 wr_q, wr_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [2:0]           nbyte_q, nbyte_d;
    logic [2:0]           acnt_q, acnt_d;
    logic [2:0]           rcnt_q, rcnt_d;
    logic                 pend_q, pend_d;
    logic                 paused_q, paused_d;

    logic [NUM_PORTS-1:0] elig;
    logic                 found;
    logic [PW-1:0]        win;
    logic                 win_wr;
    logic [1:0]           win_size;
    logic [31:0]          win_addr;
    logic [31:0]          win_wdata;
    logic                 replay;
    logic [2:0]           nxt;

    function automatic logic [2:0] nbytes(input logic [1:0] s);
        unique case (s)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        is_io = (a[17:16] == 2'b11);
    endfunction

    // Pick the winning port among eligible requests (fixed or round-robin).
    always_comb begin : arb
        int j;
        j     = 0;
        elig  = req_i & ~abort_i & ~done_q;
        found = 1'b0;
        win   = '0;
        if (ARB_MODE == 1) begin
            for (int i = 1; i <= NUM_PORTS; i++) begin
                j = int'(ptr_q) + i;
                if (j >= NUM_PORTS) j = j - NUM_PORTS;
                if (!found && elig[j]) begin
                    found = 1'b1;
                    win   = PW'(j);
                end
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && elig[i]) begin
                    found = 1'b1;
                    win   = PW'(i);
                end
            end
        end
        win_wr    = wr_i[win];
        win_size  = size_i[{win, 1'b0} +: 2];
        win_addr  = addr_i[{win, 5'b0} +: 32];
        win_wdata = wdata_i[{win, 5'b0} +: 32];
    end

    assign replay = (state_q == READ) && paused_q && pend_q;
    assign nxt    = acnt_q + 3'd1;

    // Next-state and datapath for the IDLE/READ/WRITE sequencer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = rdy ? '0 : done_q;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        base_d   = base_q;
        wdat_d   = wdat_q;
        wbyte_d  = wbyte_q;
        wr_d     = wr_q;
        ptr_d    = ptr_q;
        nbyte_d  = nbyte_q;
        acnt_d   = acnt_q;
        rcnt_d   = rcnt_q;
        pend_d   = pend_q;
        paused_d = ~rdy;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    wr_d = 1'b0;
                    if (found) begin
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        busy_d       = 1'b1;
                        ptr_d        = win;
                        base_d       = win_addr;
                        wdat_d       = win_wdata;
                        nbyte_d      = nbytes(win_size);
                        addr_d       = win_addr;
                        rdata_d      = '0;
                        rcnt_d       = '0;
                        pend_d       = 1'b0;
                        if (win_wr) begin
                            state_d = WRITE;
                            acnt_d  = '0;
                            wbyte_d = win_wdata[7:0];
                            wr_d    = ~(is_io(win_addr) & io_buffer_full);
                        end else begin
                            state_d = READ;
                            acnt_d  = 3'd1;
                        end
                    end
                end
                READ: begin
                    if (|(abort_i & grant_q)) begin
                        state_d = IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        pend_d  = 1'b0;
                    end else if (!replay) begin
                        pend_d = 1'b1;
                        if (acnt_q < nbyte_q) begin
                            addr_d = base_q + 32'(acnt_q);
                            acnt_d = nxt;
                        end
                        if (pend_q) begin
                            rdata_d[{rcnt_q[1:0], 3'b000} +: 8] = ram_data_i;
                            rcnt_d = rcnt_q + 3'd1;
                            if (rcnt_q + 3'd1 == nbyte_q) begin
                                state_d = IDLE;
                                done_d  = grant_q;
                                grant_d = '0;
                                busy_d  = 1'b0;
                                pend_d  = 1'b0;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (wr_q) begin
                        if (nxt == nbyte_q) begin
                            state_d = IDLE;
                            done_d  = grant_q;
                            grant_d = '0;
                            busy_d  = 1'b0;
                            wr_d    = 1'b0;
                        end else begin
                            acnt_d  = nxt;
                            addr_d  = addr_q + 32'd1;
                            wbyte_d = wdat_q[{nxt[1:0], 3'b000} +: 8];
                            wr_d    = ~(is_io(addr_q + 32'd1) & io_buffer_full);
                        end
                    end else begin
                        wr_d = ~(is_io(addr_q) & io_buffer_full);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            base_q   <= '0;
            wdat_q   <= '0;
            wbyte_q  <= '0;
            wr_q     <= 1'b0;
            ptr_q    <= PW'(NUM_PORTS - 1);
            nbyte_q  <= '0;
            acnt_q   <= '0;
            rcnt_q   <= '0;
            pend_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            wdat_q   <= wdat_d;
            wbyte_q  <= wbyte_d;
            wr_q     <= wr_d;
            ptr_q    <= ptr_d;
            nbyte_q  <= nbyte_d;
            acnt_q   <= acnt_d;
            rcnt_q   <= rcnt_d;
            pend_q   <= pend_d;
            paused_q <= paused_d;
        end
    end

    assign done_o     = done_q;
    assign rdata_o    = rdata_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign ram_data_o = wbyte_q;
    assign ram_addr_o = replay ? base_q + 32'(rcnt_q) : addr_q;
    assign ram_wr_o   = wr_q & rdy;

endmodule
